dense_out_streamer: RTL and testbench
=====================================

Name: dense_out_streamer

Overview:
Consumer end of the dense-layer output interface.
- Waits for a completed dense layer (`layer_done` high) and snapshots the full parallel `neuron_out` vector.
- Requantizes each 4*WIDTH accumulator to the 2*WIDTH activation width (optional ReLU, arithmetic shift, saturate).
- Streams the values one per beat on a valid/ready interface, ready to feed the next layer's input loader.
- Tracks the argmax over the raw accumulators and pulses `layer_clear` so the producing layer can be re-armed.

Parameters:
- NEURON_NB, 32, number of neurons and stream beats per frame.
- WIDTH, 8, base width; input 4*WIDTH signed, output 2*WIDTH signed.
- SHIFT, 8, arithmetic right-shift applied during requantization (0..4*WIDTH-1).
- RELU, 1, 1 = clamp negative accumulators to 0 before shifting; 0 = signed pass-through.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high reset.
- layer_done, in, 1, level from the dense layer; stays high until that layer is reset.
- neuron_out, in, [0:NEURON_NB-1] x 4*WIDTH signed, layer outputs; valid while `layer_done` is high.
- layer_clear, out, 1, one-cycle pulse requesting a re-arm of the producing layer.
- m_valid, out, 1, stream beat valid.
- m_ready, in, 1, downstream accepts the beat.
- m_data, out, 2*WIDTH signed, requantized activation.
- m_index, out, $clog2(NEURON_NB), neuron index of the current beat.
- m_last, out, 1, high on the beat with index NEURON_NB-1.
- argmax_valid, out, 1, one-cycle pulse when the argmax result is final.
- argmax_idx, out, $clog2(NEURON_NB), index of the maximum raw accumulator.
- argmax_val, out, 4*WIDTH signed, value of that maximum.
- busy, out, 1, high in every state except IDLE.

Behaviour:
- Reset: all outputs are 0, state goes to IDLE, the capture buffer is cleared, index = 0, running max = most-negative 4*WIDTH value.
- State machine: IDLE -> STREAM -> FINISH -> WAIT_LOW -> IDLE.
- IDLE:
  - If `layer_done` = 1, register all `neuron_out` into the buffer at that edge and go to STREAM.
  - `m_valid` rises the next cycle, so latency from `layer_done` sampled high to first `m_valid` is 1 cycle.
- STREAM:
  - `m_valid` = 1. `m_data` = requant(buf[idx]). `m_index` = idx. `m_last` = (idx == NEURON_NB-1).
  - On `m_valid` && `m_ready`, update the argmax: if buf[idx] > running max (strict), take it. Ties therefore keep the lowest index.
  - Then increment idx. A handshake on `m_last` goes to FINISH.
  - While `m_ready` = 0, `m_data`, `m_index` and `m_last` hold stable. Back-to-back beats are allowed (one per cycle with `m_ready` held high).
- FINISH (1 cycle):
  - `m_valid` = 0. `layer_clear` = 1 and `argmax_valid` = 1 for exactly this cycle.
  - `argmax_idx` and `argmax_val` hold until the next frame's FINISH.
  - Go to WAIT_LOW.
- WAIT_LOW:
  - Stay until `layer_done` = 0, then go to IDLE.
  - This prevents re-streaming a stale frame when the layer is not actually cleared.
- Requantization, in order:
  - If RELU, then x = max(x, 0).
  - y = x >>> SHIFT (arithmetic).
  - Saturate y to [-2^(2W-1), 2^(2W-1)-1].
- Width rules: argmax compares the full 4*WIDTH signed values. The running max register is 4*WIDTH wide.
- `neuron_out` changes after capture are ignored; the buffer alone drives the stream.
- Reset mid-frame: a reset during any state aborts the frame. No `layer_clear` or `argmax_valid` pulse is issued, and `m_valid` is 0 from the cycle after the reset edge.
- NEURON_NB = 1: the single beat carries `m_last` = 1 and `m_index` = 0.

Decomposition:
- Shared package (nn_pkg): the requant/saturate function, accumulator and activation width localparams derived from WIDTH, and the stream-beat typedef (data, index, last).
- One natural sub-module, `requant_sat` (combinational ReLU + shift + saturate). It is reused by later layer loaders.
- FSM, buffer and argmax stay in the top module.

Test Plan:
1. NEURON_NB=4, WIDTH=8, SHIFT=8, RELU=1; `neuron_out` = {256, -512, 32'h00FF_FFFF, 1000}; `m_ready` held 1 -> `m_data` 1, 0, 32767, 3 on 4 consecutive cycles; `m_index` 0..3; `m_last` only on beat 3; then `argmax_valid` pulse with idx=2, val=32'h00FF_FFFF and a `layer_clear` pulse in the same cycle.
2. Same data, `m_ready` pattern 1,0,0,1,0,1,1 -> each beat held stable while `m_ready`=0; exactly 4 handshakes; same data order.
3. Ties {5, 9, 9, 1} -> argmax_idx=1, argmax_val=9.
4. RELU=0, SHIFT=8; {-512, -32'sh0100_0000, 0, 255} -> `m_data` -2, -32768 (saturated), 0, 0; argmax_idx=3.
5. Assert reset after 2 handshakes -> `m_valid`=0 the next cycle, no `argmax_valid` and no `layer_clear`; `busy`=0. A new `layer_done` then produces a full 4-beat frame from index 0.
6. `layer_done` held high after FINISH for 10 cycles -> no new stream and `busy`=1 (WAIT_LOW). Drop it for 1 cycle, raise it again -> a new frame is captured and streamed.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared dense-layer types, widths and the requantize/saturate helper.
// Pure declarations; no timing or flow control of its own.
package nn_pkg;

    localparam int NN_WIDTH     = 8;
    localparam int ACC_W        = 4 * NN_WIDTH;
    localparam int ACT_W        = 2 * NN_WIDTH;
    localparam int NN_NEURON_NB = 32;
    localparam int NN_IDX_W     = $clog2(NN_NEURON_NB);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_FINISH,
        ST_WAIT_LOW
    } out_state_t;

    typedef struct packed {
        logic signed [ACT_W-1:0] data;
        logic [NN_IDX_W-1:0]     index;
        logic                    last;
    } beat_t;

    // Works at 64 bits so any accumulator/activation width pair up to 64 fits;
    // the caller truncates the already-saturated result to its activation width.
    function automatic logic signed [63:0] requant_f(
        input logic signed [63:0] x,
        input int                 shift,
        input bit                 relu,
        input int                 act_w
    );
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = (relu && (x < 64'sd0)) ? 64'sd0 : x;
        v  = v >>> shift;
        hi = (64'sd1 <<< (act_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            v = hi;
        else if (v < lo)
            v = lo;
        return v;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Requantizes one 4*WIDTH accumulator to a 2*WIDTH activation (ReLU, shift, saturate).
// Combinational, zero latency; no flow control.
module requant_sat
    import nn_pkg::*;
#(
    parameter int WIDTH = NN_WIDTH,
    parameter int SHIFT = 8,
    parameter int RELU  = 1
) (
    input  logic signed [4*WIDTH-1:0] acc,
    output logic signed [2*WIDTH-1:0] act
);

    assign act = (2*WIDTH)'(requant_f(64'(acc), SHIFT, RELU != 0, 2*WIDTH));

endmodule

// File: rtl/dense_out_streamer.sv
// Snapshots a finished dense layer, streams requantized activations and tracks the argmax.
// First beat 1 cycle after layer_done is sampled; beats held stable while m_ready is low.
// Re-arms the producer with a layer_clear pulse, then waits for layer_done to drop.
module dense_out_streamer
    import nn_pkg::*;
#(
    parameter  int NEURON_NB = 32,
    parameter  int WIDTH     = NN_WIDTH,
    parameter  int SHIFT     = 8,
    parameter  int RELU      = 1,
    localparam int ACCW      = 4 * WIDTH,
    localparam int ACTW      = 2 * WIDTH,
    localparam int IDXW      = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   layer_done,
    input  logic signed [ACCW-1:0] neuron_out [0:NEURON_NB-1],
    output logic                   layer_clear,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic signed [ACTW-1:0] m_data,
    output logic [IDXW-1:0]        m_index,
    output logic                   m_last,
    output logic                   argmax_valid,
    output logic [IDXW-1:0]        argmax_idx,
    output logic signed [ACCW-1:0] argmax_val,
    output logic                   busy
);

    localparam logic signed [ACCW-1:0] ACC_MIN  = {1'b1, {(ACCW-1){1'b0}}};
    localparam logic [IDXW-1:0]        LAST_IDX = IDXW'(NEURON_NB - 1);

    out_state_t             state_q, state_n;
    logic signed [ACCW-1:0] cap_buf [0:NEURON_NB-1];
    logic [IDXW-1:0]        idx_q;
    logic signed [ACCW-1:0] run_max_q;
    logic [IDXW-1:0]        run_idx_q;
    logic                   at_last;
    logic                   beat_fire;
    logic                   take_new;

    assign at_last   = (idx_q == LAST_IDX);
    assign beat_fire = m_valid && m_ready;
    // Strict compare: ties keep the earliest index.
    assign take_new  = (cap_buf[idx_q] > run_max_q);

    requant_sat #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT),
        .RELU  (RELU)
    ) u_requant (
        .acc (cap_buf[idx_q]),
        .act (m_data)
    );

    assign m_index = idx_q;
    assign m_last  = m_valid && at_last;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_n;
    end

    always_comb begin
        state_n      = state_q;
        m_valid      = 1'b0;
        layer_clear  = 1'b0;
        argmax_valid = 1'b0;
        busy         = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (layer_done)
                    state_n = ST_STREAM;
            end
            ST_STREAM: begin
                m_valid = 1'b1;
                if (m_ready && at_last)
                    state_n = ST_FINISH;
            end
            ST_FINISH: begin
                layer_clear  = 1'b1;
                argmax_valid = 1'b1;
                state_n      = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!layer_done)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NEURON_NB; i++)
                cap_buf[i] <= '0;
            idx_q      <= '0;
            run_max_q  <= ACC_MIN;
            run_idx_q  <= '0;
            argmax_idx <= '0;
            argmax_val <= '0;
        end else begin
            if (state_q == ST_IDLE && layer_done) begin
                cap_buf   <= neuron_out;
                idx_q     <= '0;
                run_max_q <= ACC_MIN;
                run_idx_q <= '0;
            end
            if (beat_fire) begin
                if (take_new) begin
                    run_max_q <= cap_buf[idx_q];
                    run_idx_q <= idx_q;
                end
                // Final result is latched on the last beat so it is valid during the pulse.
                if (at_last) begin
                    idx_q      <= '0;
                    argmax_idx <= take_new ? idx_q : run_idx_q;
                    argmax_val <= take_new ? cap_buf[idx_q] : run_max_q;
                end else begin
                    idx_q <= idx_q + IDXW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dense_out_streamer.sv
// Directed bench for dense_out_streamer: two instances (ReLU on / off) share stimulus,
// one is observed at a time; expectations are hand-computed constants.
module tb_dense_out_streamer;

    logic               clk = 1'b0;
    logic               reset;
    logic               layer_done;
    logic               m_ready;
    logic signed [31:0] nout [0:3];
    logic               sel;

    logic               a_clear, a_valid, a_last, a_amv, a_busy;
    logic signed [15:0] a_data;
    logic [1:0]         a_index, a_aidx;
    logic signed [31:0] a_aval;
    logic               b_clear, b_valid, b_last, b_amv, b_busy;
    logic signed [15:0] b_data;
    logic [1:0]         b_index, b_aidx;
    logic signed [31:0] b_aval;

    logic               o_clear, o_valid, o_last, o_amv, o_busy;
    logic signed [15:0] o_data;
    logic [1:0]         o_index, o_aidx;
    logic signed [31:0] o_aval;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dense_out_streamer #(.NEURON_NB(4), .WIDTH(8), .SHIFT(8), .RELU(1)) dut_a (
        .clk(clk), .reset(reset), .layer_done(layer_done), .neuron_out(nout),
        .layer_clear(a_clear), .m_valid(a_valid), .m_ready(m_ready), .m_data(a_data),
        .m_index(a_index), .m_last(a_last), .argmax_valid(a_amv), .argmax_idx(a_aidx),
        .argmax_val(a_aval), .busy(a_busy)
    );

    dense_out_streamer #(.NEURON_NB(4), .WIDTH(8), .SHIFT(8), .RELU(0)) dut_b (
        .clk(clk), .reset(reset), .layer_done(layer_done), .neuron_out(nout),
        .layer_clear(b_clear), .m_valid(b_valid), .m_ready(m_ready), .m_data(b_data),
        .m_index(b_index), .m_last(b_last), .argmax_valid(b_amv), .argmax_idx(b_aidx),
        .argmax_val(b_aval), .busy(b_busy)
    );

    always_comb begin
        o_clear = sel ? b_clear : a_clear;
        o_valid = sel ? b_valid : a_valid;
        o_last  = sel ? b_last  : a_last;
        o_amv   = sel ? b_amv   : a_amv;
        o_busy  = sel ? b_busy  : a_busy;
        o_data  = sel ? b_data  : a_data;
        o_index = sel ? b_index : a_index;
        o_aidx  = sel ? b_aidx  : a_aidx;
        o_aval  = sel ? b_aval  : a_aval;
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_data(input logic signed [31:0] v0, input logic signed [31:0] v1,
                            input logic signed [31:0] v2, input logic signed [31:0] v3);
        nout[0] = v0;
        nout[1] = v1;
        nout[2] = v2;
        nout[3] = v3;
    endtask

    // Entered at a negedge in IDLE; leaves at a negedge in WAIT_LOW with layer_done still high.
    task automatic stream_frame(input int e0, input int e1, input int e2, input int e3,
                                input int exp_ai, input longint exp_av,
                                input logic [15:0] pat, input int plen);
        int   exp_d [4];
        int   k = 0;
        int   p = 0;
        int   cyc = 0;
        logic rdy;
        exp_d = '{e0, e1, e2, e3};
        layer_done = 1'b1;
        m_ready    = 1'b0;
        @(negedge clk);
        while (k < 4 && cyc < 40) begin
            rdy = (p < plen) ? pat[p] : 1'b1;
            p++;
            m_ready = rdy;
            check_val("m_valid", o_valid, 1);
            check_val("m_data", o_data, exp_d[k]);
            check_val("m_index", o_index, k);
            check_val("m_last", o_last, (k == 3) ? 1 : 0);
            check_val("no_early_clear", o_clear, 0);
            if (o_valid && rdy)
                k++;
            @(negedge clk);
            cyc++;
        end
        if (k < 4)
            check_val("stream_timeout", k, 4);
        m_ready = 1'b0;
        check_val("fin_m_valid", o_valid, 0);
        check_val("fin_argmax_valid", o_amv, 1);
        check_val("fin_layer_clear", o_clear, 1);
        check_val("fin_argmax_idx", o_aidx, exp_ai);
        check_val("fin_argmax_val", o_aval, exp_av);
        @(negedge clk);
        check_val("wl_argmax_valid", o_amv, 0);
        check_val("wl_layer_clear", o_clear, 0);
        check_val("wl_busy", o_busy, 1);
        check_val("wl_argmax_idx_hold", o_aidx, exp_ai);
    endtask

    task automatic drop_done();
        layer_done = 1'b0;
        @(negedge clk);
        check_val("idle_busy", o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        layer_done = 1'b0;
        m_ready    = 1'b0;
        sel        = 1'b0;
        set_data(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_val("rst_m_valid", o_valid, 0);
        check_val("rst_busy", o_busy, 0);
        check_val("rst_layer_clear", o_clear, 0);
        check_val("rst_argmax_valid", o_amv, 0);
        check_val("rst_argmax_idx", o_aidx, 0);
        check_val("rst_argmax_val", o_aval, 0);
        check_val("rst_m_data", o_data, 0);
        check_val("rst_m_last", o_last, 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic frame, ready always high
        set_data(256, -512, 32'h00FF_FFFF, 1000);
        stream_frame(1, 0, 32767, 3, 2, 64'h00FF_FFFF, 16'hFFFF, 16);
        drop_done();

        // Backpressure pattern 1,0,0,1,0,1,1
        stream_frame(1, 0, 32767, 3, 2, 64'h00FF_FFFF, 16'h0069, 7);
        drop_done();

        // Ties keep the lowest index
        set_data(5, 9, 9, 1);
        stream_frame(0, 0, 0, 0, 1, 9, 16'hFFFF, 16);
        drop_done();

        // Signed pass-through with saturation (RELU=0 instance)
        sel = 1'b1;
        set_data(-512, -32'sh0100_0000, 0, 255);
        stream_frame(-2, -32768, 0, 0, 3, 255, 16'hFFFF, 16);
        drop_done();
        sel = 1'b0;

        // Reset after two handshakes aborts the frame
        set_data(256, -512, 32'h00FF_FFFF, 1000);
        layer_done = 1'b1;
        m_ready    = 1'b1;
        repeat (3) @(negedge clk);
        check_val("abort_pre_index", o_index, 2);
        reset      = 1'b1;
        layer_done = 1'b0;
        m_ready    = 1'b0;
        @(negedge clk);
        check_val("abort_m_valid", o_valid, 0);
        check_val("abort_busy", o_busy, 0);
        check_val("abort_argmax_valid", o_amv, 0);
        check_val("abort_layer_clear", o_clear, 0);
        reset = 1'b0;
        @(negedge clk);
        check_val("post_abort_argmax_valid", o_amv, 0);
        check_val("post_abort_layer_clear", o_clear, 0);
        check_val("post_abort_busy", o_busy, 0);
        stream_frame(1, 0, 32767, 3, 2, 64'h00FF_FFFF, 16'hFFFF, 16);

        // layer_done held high: no re-stream of a stale frame
        for (int i = 0; i < 10; i++) begin
            m_ready = 1'b1;
            @(negedge clk);
            check_val("hold_m_valid", o_valid, 0);
            check_val("hold_busy", o_busy, 1);
        end
        m_ready = 1'b0;
        drop_done();
        set_data(5, 9, 9, 1);
        stream_frame(0, 0, 0, 0, 1, 9, 16'hFFFF, 16);
        drop_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
